// File: rtl/mmio_pkg.sv
// Shared types, constants and helpers for the MMIO bridge slice.
package mmio_pkg;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_RAM,
      REG_LSIO
   } mmio_region_e;

   localparam logic [31:0] MMIO_UNMAPPED_DATA = 32'hdeadbeef;

   // Byte-lane patterns the slaves can honour; full-word writes must be word aligned.
   function automatic logic mmio_strb_legal(input logic [3:0] wstrb, input logic [1:0] addr_lo);
      logic legal;
      case (wstrb)
         4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b1000, 4'b0011, 4'b1100: legal = 1'b1;
         4'b1111:                   legal = (addr_lo == 2'b00);
         default:                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mmio_rsp_hold.sv
// One-entry response skid register: captures rdata/err when the first
// response cycle stalls, clears on the response handshake.
module mmio_rsp_hold (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        capture_i,
   input  logic        clear_i,
   input  logic [31:0] rdata_i,
   input  logic        err_i,
   output logic        hold_valid_o,
   output logic [31:0] hold_rdata_o,
   output logic        hold_err_o
);
   import mmio_pkg::*;

   logic        valid_q, valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   always_comb begin
      valid_d = valid_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (capture_i) begin
         valid_d = 1'b1;
         rdata_d = rdata_i;
         err_d   = err_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign hold_valid_o = valid_q;
   assign hold_rdata_o = rdata_q;
   assign hold_err_o   = err_q;

endmodule

// File: rtl/mmio_bridge.sv
// CPU valid/ready data port to single-cycle RAM/LSIO slave bus bridge.
// Optional MMIO_BUS_ERR_EN: error responses for unmapped and misaligned accesses.
module mmio_bridge #(
   parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
   parameter int unsigned RAM_SIZE_LOG2  = 14,
   parameter logic [31:0] LSIO_BASE      = 32'h1000_0000,
   parameter int unsigned LSIO_SIZE_LOG2 = 6
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [3:0]  req_wstrb_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        ram_enable_o,
   output logic        lsio_enable_o,
   output logic [3:0]  bus_wstrb_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_addr_prev_o,
   output logic [31:0] bus_wvalue_o,
   input  logic [31:0] ram_rvalue_i,
   input  logic [31:0] lsio_rvalue_i
);
   import mmio_pkg::*;

   logic         accept;
   logic         ram_hit, lsio_hit, strb_ok;
   logic         req_err;
   mmio_region_e req_region;

   logic         rsp_valid_q, rsp_valid_d;
   logic [31:0]  addr_prev_q, addr_prev_d;
   mmio_region_e last_region_q, last_region_d;
   logic         last_is_read_q, last_is_read_d;
   logic         last_err_q, last_err_d;

   logic [31:0]  rdata_mux;
   logic         hold_valid, hold_err;
   logic [31:0]  hold_rdata;

   assign ram_hit  = (req_addr_i >> RAM_SIZE_LOG2) == (RAM_BASE >> RAM_SIZE_LOG2);
   assign lsio_hit = (req_addr_i >> LSIO_SIZE_LOG2) == (LSIO_BASE >> LSIO_SIZE_LOG2);

`ifdef MMIO_BUS_ERR_EN
   assign strb_ok = mmio_strb_legal(req_wstrb_i, req_addr_i[1:0]);
`else
   assign strb_ok = 1'b1;
`endif

   always_comb begin
      req_region = REG_NONE;
      if (strb_ok && ram_hit)       req_region = REG_RAM;
      else if (strb_ok && lsio_hit) req_region = REG_LSIO;
   end

`ifdef MMIO_BUS_ERR_EN
   assign req_err = (req_region == REG_NONE);
`else
   assign req_err = 1'b0;
`endif

   // Gating with rstn_i keeps slave enables quiet while reset is held.
   assign req_ready_o   = !rsp_valid_q || rsp_ready_i;
   assign accept        = rstn_i && req_valid_i && req_ready_o;
   assign ram_enable_o  = accept && (req_region == REG_RAM);
   assign lsio_enable_o = accept && (req_region == REG_LSIO);

   assign bus_addr_o      = req_addr_i;
   assign bus_wstrb_o     = req_wstrb_i;
   assign bus_wvalue_o    = req_wdata_i;
   assign bus_addr_prev_o = addr_prev_q;

   always_comb begin
      rsp_valid_d    = rsp_valid_q;
      addr_prev_d    = addr_prev_q;
      last_region_d  = last_region_q;
      last_is_read_d = last_is_read_q;
      last_err_d     = last_err_q;
      if (accept) begin
         rsp_valid_d    = 1'b1;
         addr_prev_d    = req_addr_i;
         last_region_d  = req_region;
         last_is_read_d = (req_wstrb_i == 4'b0000);
         last_err_d     = req_err;
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rsp_valid_q    <= 1'b0;
         addr_prev_q    <= '0;
         last_region_q  <= REG_NONE;
         last_is_read_q <= 1'b0;
         last_err_q     <= 1'b0;
      end else begin
         rsp_valid_q    <= rsp_valid_d;
         addr_prev_q    <= addr_prev_d;
         last_region_q  <= last_region_d;
         last_is_read_q <= last_is_read_d;
         last_err_q     <= last_err_d;
      end
   end

   always_comb begin
      rdata_mux = MMIO_UNMAPPED_DATA;
      case (last_region_q)
         REG_RAM:  rdata_mux = ram_rvalue_i;
         REG_LSIO: rdata_mux = lsio_rvalue_i;
         default:  rdata_mux = MMIO_UNMAPPED_DATA;
      endcase
      if (!last_is_read_q)  rdata_mux = '0;
      else if (last_err_q)  rdata_mux = MMIO_UNMAPPED_DATA;
   end

   // Live slave data is only trustworthy in the first response cycle; a stall freezes it here.
   mmio_rsp_hold u_hold (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .capture_i    (rsp_valid_q && !rsp_ready_i && !hold_valid),
      .clear_i      (rsp_valid_q && rsp_ready_i),
      .rdata_i      (rdata_mux),
      .err_i        (last_err_q),
      .hold_valid_o (hold_valid),
      .hold_rdata_o (hold_rdata),
      .hold_err_o   (hold_err)
   );

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = hold_valid ? hold_rdata : rdata_mux;
   assign rsp_err_o   = hold_valid ? hold_err : last_err_q;

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Upstream neighbour of the low-speed IO peripheral block. Converts the CPU data port's valid/ready request and response handshake into the shared single-cycle slave bus.
- Slave bus signals: enable, wstrb, addr, addr_prev, wvalue, rvalue. Read data is valid the cycle after enable and is decoded from addr_prev.
- Decodes two regions, RAM and LSIO. Registers addr_prev, muxes read data and holds the response under backpressure.

Parameters:
- RAM_BASE, 32'h0000_0000, RAM region base; aligned to 2**RAM_SIZE_LOG2.
- RAM_SIZE_LOG2, 14, RAM region size in bytes, log2.
- LSIO_BASE, 32'h1000_0000, LSIO region base; aligned to 2**LSIO_SIZE_LOG2.
- LSIO_SIZE_LOG2, 6, LSIO region size in bytes, log2.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  bridge can accept a request
- req_addr_i  in  32  byte address
- req_wstrb_i  in  4  0000 = read; otherwise write byte lanes
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  CPU accepts response
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_err_o  out  1  error flag (MMIO_BUS_ERR_EN only; otherwise tied 0)
- ram_enable_o, lsio_enable_o  out  1 each  per-slave enable
- bus_wstrb_o  out  4  shared write strobe
- bus_addr_o  out  32  shared address
- bus_addr_prev_o  out  32  address of the last accepted request
- bus_wvalue_o  out  32  shared write data
- ram_rvalue_i, lsio_rvalue_i  in  32 each  slave read data, valid the cycle after enable

Behaviour:
- Reset (synchronous, rstn_i low at a clock edge):
  - rsp_valid_o=0, hold buffer empty, bus_addr_prev_o=0, last-region register=NONE, rsp_err_o=0.
  - req_ready_o=1 combinationally after reset.
- Accept rule:
  - req_ready_o = !rsp_valid_o || rsp_ready_i (one-deep pipeline; back-to-back accepts at one per cycle).
  - A request is accepted when req_valid_i && req_ready_o.
- Bus drive:
  - bus_addr_o, bus_wstrb_o and bus_wvalue_o pass through combinationally from the request.
  - X-enable = accept && (req_addr_i in X region). At most one enable is asserted.
  - Region hit test: (addr >> SIZE_LOG2) == (BASE >> SIZE_LOG2).
- On accept (registered):
  - bus_addr_prev_o <= req_addr_i.
  - last_region <= RAM / LSIO / NONE.
  - last_is_read <= (wstrb==0).
  - rsp_valid_o <= 1.
- Without accept:
  - rsp_valid_o clears when rsp_ready_i is high.
  - bus_addr_prev_o and last_region hold.
- Response data:
  - Write: rdata=0.
  - Read from RAM or LSIO: the live slave rvalue in the first response cycle.
  - Read from NONE: 32'hdeadbeef.
- Hold buffer:
  - If rsp_valid_o && !rsp_ready_i in the first response cycle, capture the muxed rdata into hold_q and set hold_valid.
  - While hold_valid, rsp_rdata_o = hold_q. Slave rvalue may change (e.g. timer) and must not leak through.
  - hold_valid clears on the rsp handshake.
- The response is stable (valid, rdata, err) from assertion until rsp_ready_i.
- Read side effects fire exactly once per accepted read, because the enable is tied to the accept.
- Stall with no new request: bus_addr_prev_o is unchanged, so slaves keep decoding the same address.
- Simultaneous rsp handshake and new accept: the new response replaces the old in the same edge; the hold buffer is cleared, not captured.
- Reset mid-transaction: the pending response is dropped; no slave enable is asserted during reset.

Optional Feature:
- Macro MMIO_BUS_ERR_EN.
- When defined:
  - Unmapped accesses respond with rsp_err_o=1.
  - Misaligned accesses also respond with rsp_err_o=1 and assert no enable. A misaligned access is a wstrb that is not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111, or a 1111 write with addr[1:0]!=0.
  - Error read rdata = 32'hdeadbeef.
- When undefined:
  - rsp_err_o=0.
  - Unmapped reads return 32'hdeadbeef; unmapped writes are silently dropped with a normal response.
  - No alignment check.

Decomposition:
- Package mmio_pkg:
  - enum mmio_region_e {REG_NONE, REG_RAM, REG_LSIO}.
  - localparam MMIO_UNMAPPED_DATA = 32'hdeadbeef.
  - function mmio_strb_legal(wstrb, addr_lo).
- Sub-module mmio_rsp_hold: one-entry response skid register (valid, rdata, err) with capture-on-stall and clear-on-handshake.

Test Plan:
- RAM read 0x0000_0010, rsp_ready=1, ram_rvalue=0x1234_5678 next cycle -> ram_enable=1 for 1 cycle, bus_addr_prev=0x10, rsp_rdata=0x1234_5678 one cycle after accept.
- Back-to-back LSIO reads 0x1000_0008, then 0x1000_000C -> lsio_enable high on 2 consecutive cycles, responses in order, 1 per cycle.
- LSIO read with rsp_ready=0 for 3 cycles while lsio_rvalue changes 5->6->7 -> rsp_rdata stays 5, req_ready=0 throughout, single enable pulse.
- Write 0x1000_0000 wstrb=1111 wdata=0x41 -> lsio_enable=1, bus_wvalue=0x41, rsp_rdata=0, rsp_err=0.
- Read 0x2000_0000 -> no enable, rdata=0xdeadbeef; rsp_err=1 only with MMIO_BUS_ERR_EN.
- rstn_i low during a stalled response -> rsp_valid=0 the next cycle, req_ready=1, bus_addr_prev=0.
